// File: rtl/md_sched.sv
// Multiply/divide sequencer: computes HI/LO results at issue into shadow registers,
// holds busy for a fixed per-class latency, then commits to architectural HI/LO.
module md_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        inter,
    input  logic        use_hilo,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic {IDLE, RUN} state_e;

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    state_e      state;
    logic [3:0]  cnt;
    logic [31:0] sh_hi, sh_lo;
    logic        sh_ok;

    logic        issue, is_md;
    logic [63:0] prod_s, prod_u;
    logic        div_signed, neg_q, neg_r;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag;
    logic [31:0] res_hi, res_lo;
    logic        res_ok;
    logic [3:0]  n_load;

    assign issue = start & ~inter & (state == IDLE) & (op <= OP_MTLO);
    assign is_md = (op <= OP_DIVU);
    assign stall = use_hilo & (busy | (start & ~inter & is_md));

    assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Signed divide on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
    assign div_signed = (op == OP_DIV);
    assign a_mag      = (div_signed && rs_val[31]) ? -rs_val : rs_val;
    assign b_mag      = (div_signed && rt_val[31]) ? -rt_val : rt_val;
    assign b_safe     = (rt_val == 32'd0) ? 32'd1 : b_mag;
    assign q_mag      = a_mag / b_safe;
    assign r_mag      = a_mag % b_safe;
    assign neg_q      = div_signed & (rs_val[31] ^ rt_val[31]);
    assign neg_r      = div_signed & rs_val[31];

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
        res_ok = 1'b1;
        n_load = MULT_N;
        case (op)
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV, OP_DIVU: begin
                res_hi = neg_r ? -r_mag : r_mag;
                res_lo = neg_q ? -q_mag : q_mag;
                res_ok = (rt_val != 32'd0);
                n_load = DIV_N;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            sh_hi <= 32'd0;
            sh_lo <= 32'd0;
            sh_ok <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (issue) begin
                        if (is_md) begin
                            sh_hi <= res_hi;
                            sh_lo <= res_lo;
                            sh_ok <= res_ok;
                            cnt   <= n_load;
                            busy  <= 1'b1;
                            done  <= (n_load == 4'd1);
                            state <= RUN;
                        end else if (op == OP_MTHI) begin
                            hi <= rs_val;
                        end else begin
                            lo <= rs_val;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt - 4'd1;
                    // done is registered, so it is raised one edge ahead of the final cycle.
                    if (cnt == 4'd1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                        if (sh_ok) begin
                            hi <= sh_hi;
                            lo <= sh_lo;
                        end
                    end else begin
                        done <= (cnt == 4'd2);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
